mips32_mem_arbiter: RTL and testbench

- Arbitrates one single-port 1024x32 program/data memory between three requesters: the instruction-fetch port (im), the load/store data port (dm) and a program loader/debug port (ldr).
- Sits between the mips32 core and the memory macro.
- Grants one access per cycle, routes read data back to the winning port one cycle later, and guarantees fetch forward progress with a starvation counter.

---
 rtl/mips32_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mips32_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_mem_arbiter.sv
// Single-port memory arbiter for the mips32 core: loader > starved fetch > data > fetch.
// Grants one access per cycle and steers read data to the winner one cycle later.
module mips32_mem_arbiter #(
  parameter int unsigned AW       = 10,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          core_halt,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_gnt,
  output logic          ldr_rvalid,
  output logic [DW-1:0] ldr_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  input  logic          im_req,
  input  logic [AW-1:0] im_addr,
  output logic          im_gnt,
  output logic          im_rvalid,
  output logic [DW-1:0] im_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_LDR  = 2'd1,
    SRC_DM   = 2'd2,
    SRC_IM   = 2'd3
  } src_e;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  src_e       rsp_src_q, rsp_src_d;
  logic [3:0] im_wait_q, im_wait_d;
  logic       dm_req_m, im_req_m;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_src_q <= SRC_NONE;
      im_wait_q <= '0;
    end else begin
      rsp_src_q <= rsp_src_d;
      im_wait_q <= im_wait_d;
    end
  end

  always_comb begin
    ldr_gnt   = 1'b0;
    dm_gnt    = 1'b0;
    im_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rsp_src_d = SRC_NONE;
    im_wait_d = im_wait_q;
    dm_req_m  = dm_req & ~core_halt;
    im_req_m  = im_req & ~core_halt;

    if (ldr_req) begin
      ldr_gnt   = 1'b1;
      mem_en    = 1'b1;
      mem_we    = ldr_we;
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
      if (!ldr_we) rsp_src_d = SRC_LDR;
    end else if (im_req_m && (im_wait_q == WAIT_MAX)) begin
      im_gnt    = 1'b1;
      mem_en    = 1'b1;
      mem_addr  = im_addr;
      rsp_src_d = SRC_IM;
    end else if (dm_req_m) begin
      dm_gnt    = 1'b1;
      mem_en    = 1'b1;
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      if (!dm_we) rsp_src_d = SRC_DM;
    end else if (im_req_m) begin
      im_gnt    = 1'b1;
      mem_en    = 1'b1;
      mem_addr  = im_addr;
      rsp_src_d = SRC_IM;
    end

    // Halt freezes the starvation count; otherwise it tracks consecutive denials.
    if (!core_halt) begin
      if (!im_req || im_gnt)         im_wait_d = '0;
      else if (im_wait_q < WAIT_MAX) im_wait_d = im_wait_q + 4'd1;
    end

    ldr_rvalid = (rsp_src_q == SRC_LDR);
    dm_rvalid  = (rsp_src_q == SRC_DM);
    im_rvalid  = (rsp_src_q == SRC_IM);
    ldr_rdata  = ldr_rvalid ? mem_rdata : '0;
    dm_rdata   = dm_rvalid  ? mem_rdata : '0;
    im_rdata   = im_rvalid  ? mem_rdata : '0;

    // Combinational request-path outputs must read as zero while reset is held.
    if (!rst_n) begin
      ldr_gnt   = 1'b0;
      dm_gnt    = 1'b0;
      im_gnt    = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed bench for mips32_mem_arbiter: grant checks inline, read responses
// checked by a scoreboard monitor against a queue of expected {source, data, cycle}.
module tb_mips32_mem_arbiter;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam logic [1:0] S_LDR = 2'd1, S_DM = 2'd2, S_IM = 2'd3;

  logic          clk, rst_n, core_halt;
  logic          ldr_req, ldr_we, ldr_gnt, ldr_rvalid;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata, ldr_rdata;
  logic          dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          im_req, im_gnt, im_rvalid;
  logic [AW-1:0] im_addr;
  logic [DW-1:0] im_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mips32_mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .core_halt(core_halt),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .im_req(im_req), .im_addr(im_addr),
    .im_gnt(im_gnt), .im_rvalid(im_rvalid), .im_rdata(im_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-first synchronous memory
  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        mem_rdata     <= mem_wdata;
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  src;
    logic [31:0] data;
    int unsigned due;
  } rsp_t;
  rsp_t exp_q[$];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_rd(input logic [1:0] src, input logic [31:0] data);
    rsp_t r;
    r.src  = src;
    r.data = data;
    r.due  = cyc + 1;
    exp_q.push_back(r);
  endtask

  task automatic idle();
    core_halt = 1'b0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
    dm_req  = 1'b0; dm_we  = 1'b0; dm_addr  = '0; dm_wdata  = '0;
    im_req  = 1'b0; im_addr = '0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Response monitor
  always @(negedge clk) begin
    int         nv;
    logic [1:0] src;
    logic [31:0] data, others;
    rsp_t       r;
    if (rst_n) begin
      nv = int'(ldr_rvalid) + int'(dm_rvalid) + int'(im_rvalid);
      if (nv > 1) begin
        chk("rvalid_onehot", nv, 1);
      end else if (nv == 1) begin
        src    = ldr_rvalid ? S_LDR : (dm_rvalid ? S_DM : S_IM);
        data   = ldr_rvalid ? ldr_rdata : (dm_rvalid ? dm_rdata : im_rdata);
        others = (ldr_rvalid ? '0 : ldr_rdata) | (dm_rvalid ? '0 : dm_rdata) |
                 (im_rvalid ? '0 : im_rdata);
        if (exp_q.size() == 0) begin
          chk("unexpected_rvalid", {30'd0, src}, 0);
        end else begin
          r = exp_q.pop_front();
          chk("rsp_src", {30'd0, src}, {30'd0, r.src});
          chk("rsp_data", data, r.data);
          chk("rsp_cycle", cyc, r.due);
          chk("rsp_other_rdata", others, 0);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        r = exp_q.pop_front();
        chk("missing_rvalid", 0, {30'd0, r.src});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    // Reset with requests present: every output must stay quiet
    next();
    ldr_req = 1'b1; ldr_wdata = 32'h5555_5555;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd5; dm_wdata = 32'hFFFF_FFFF;
    im_req = 1'b1;
    @(negedge clk);
    chk("rst_gnt", {29'd0, ldr_gnt, dm_gnt, im_gnt}, 0);
    chk("rst_mem_en_we", {30'd0, mem_en, mem_we}, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rvalid", {29'd0, ldr_rvalid, dm_rvalid, im_rvalid}, 0);
    chk("rst_rdata", ldr_rdata | dm_rdata | im_rdata, 0);
    chk("rst_im_wait", dut.im_wait_q, 0);
    chk("rst_rsp_src", dut.rsp_src_q, 0);
    next(); idle(); rst_n = 1'b1;

    // Loader preloads 0xA0..0xA3
    for (int i = 0; i < 4; i++) begin
      next(); idle();
      ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = AW'(i); ldr_wdata = 32'hA0 + 32'(i);
      @(negedge clk);
      chk("preload_gnt", {31'd0, ldr_gnt}, 1);
      chk("preload_we", {31'd0, mem_we}, 1);
    end

    // Fetch stream
    for (int i = 0; i < 4; i++) begin
      next(); idle();
      im_req = 1'b1; im_addr = AW'(i);
      @(negedge clk);
      chk("fetch_gnt", {31'd0, im_gnt}, 1);
      chk("fetch_mem_we", {31'd0, mem_we}, 0);
      chk("fetch_mem_addr", 32'(mem_addr), 32'(i));
      expect_rd(S_IM, 32'hA0 + 32'(i));
    end

    // Store beats fetch, fetch follows, then load the stored word
    next(); idle();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd5; dm_wdata = 32'hDEADBEEF;
    im_req = 1'b1; im_addr = 10'd1;
    @(negedge clk);
    chk("store_gnt", {30'd0, dm_gnt, im_gnt}, 32'b10);
    chk("store_mem_we", {31'd0, mem_we}, 1);
    chk("store_mem_addr", 32'(mem_addr), 5);
    chk("store_mem_wdata", mem_wdata, 32'hDEADBEEF);
    next(); dm_req = 1'b0;
    @(negedge clk);
    chk("after_store_im_gnt", {31'd0, im_gnt}, 1);
    expect_rd(S_IM, 32'hA1);
    next(); idle();
    dm_req = 1'b1; dm_addr = 10'd5;
    @(negedge clk);
    chk("load_gnt", {31'd0, dm_gnt}, 1);
    expect_rd(S_DM, 32'hDEADBEEF);
    next(); idle();
    im_req = 1'b1; im_addr = 10'd2;
    @(negedge clk);
    chk("b2b_im_gnt", {31'd0, im_gnt}, 1);
    expect_rd(S_IM, 32'hA2);

    // Starvation: dm held, im denied 4 cycles then granted on the 5th
    next(); idle();
    dm_req = 1'b1; dm_addr = 10'd3; im_req = 1'b1; im_addr = 10'd0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("starve_im_gnt", {31'd0, im_gnt}, (k == 5) ? 1 : 0);
      chk("starve_dm_gnt", {31'd0, dm_gnt}, (k == 5) ? 0 : 1);
      chk("starve_wait", dut.im_wait_q, (k == 6) ? 0 : 32'(k - 1));
      if (k == 5) expect_rd(S_IM, 32'hA0);
      else        expect_rd(S_DM, 32'hA3);
      if (k < 6) next();
    end
    for (int k = 0; k < 3; k++) begin
      next();
      @(negedge clk);
      chk("resat_dm_gnt", {31'd0, dm_gnt}, 1);
      expect_rd(S_DM, 32'hA3);
    end

    // Loader outranks a saturated fetch
    next();
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 10'd1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ldr_prio_gnt", {29'd0, ldr_gnt, dm_gnt, im_gnt}, 32'b100);
      chk("ldr_prio_wait", dut.im_wait_q, 4);
      expect_rd(S_LDR, 32'hA1);
      next();
    end
    ldr_req = 1'b0;
    @(negedge clk);
    chk("starved_im_wins", {30'd0, dm_gnt, im_gnt}, 32'b01);
    expect_rd(S_IM, 32'hA0);
    next();
    @(negedge clk);
    chk("dm_resumes", {30'd0, dm_gnt, im_gnt}, 32'b10);
    expect_rd(S_DM, 32'hA3);

    // Halt: only loader served, im_wait frozen
    next(); idle();
    for (int k = 0; k < 2; k++) begin
      next();
      dm_req = 1'b1; dm_addr = 10'd3; im_req = 1'b1; im_addr = 10'd0;
      @(negedge clk);
      expect_rd(S_DM, 32'hA3);
    end
    next();
    core_halt = 1'b1;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 10'd7; ldr_wdata = 32'h12345678;
    @(negedge clk);
    chk("halt_ldr_gnt", {29'd0, ldr_gnt, dm_gnt, im_gnt}, 32'b100);
    chk("halt_mem_we", {31'd0, mem_we}, 1);
    chk("halt_mem_addr", 32'(mem_addr), 7);
    chk("halt_mem_wdata", mem_wdata, 32'h12345678);
    chk("halt_wait", dut.im_wait_q, 2);
    next(); ldr_req = 1'b0;
    @(negedge clk);
    chk("halt_no_gnt", {29'd0, ldr_gnt, dm_gnt, im_gnt}, 0);
    chk("halt_mem_en", {31'd0, mem_en}, 0);
    chk("halt_wait_hold", dut.im_wait_q, 2);
    next(); ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 10'd7;
    @(negedge clk);
    chk("halt_ldr_rd_gnt", {29'd0, ldr_gnt, dm_gnt, im_gnt}, 32'b100);
    expect_rd(S_LDR, 32'h12345678);
    next(); idle();
    @(negedge clk);
    chk("halt_release_wait", dut.im_wait_q, 2);

    // Reset right after a load grant drops its response
    next(); idle();
    dm_req = 1'b1; dm_addr = 10'd5;
    @(negedge clk);
    chk("pre_rst_dm_gnt", {31'd0, dm_gnt}, 1);
    #2;
    rst_n = 1'b0;
    idle();
    next();
    @(negedge clk);
    chk("midrst_rvalid", {29'd0, ldr_rvalid, dm_rvalid, im_rvalid}, 0);
    chk("midrst_rdata", ldr_rdata | dm_rdata | im_rdata, 0);
    chk("midrst_mem", {30'd0, mem_en, mem_we}, 0);
    next(); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rsp_src", dut.rsp_src_q, 0);
    chk("post_rst_rvalid", {29'd0, ldr_rvalid, dm_rvalid, im_rvalid}, 0);
    next(); next();
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
